// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready handshakes on both sides.
// Logic ops and add/sub finish one cycle after acceptance. Shifts walk a
// working register one bit per cycle unless SEQ_ALU_FAST_SHIFT_EN is
// defined, in which case a barrel shifter gives every op a latency of one.
module seq_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             equal,
    output logic             carry
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             eq_pend_q, eq_pend_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             equal_q, equal_d;
    logic             carry_q, carry_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             is_shift;
    logic [WIDTH-1:0] work_step;

    assign shamt     = in_B[SHW-1:0];
    assign sum_ext   = {1'b0, in_A} + {1'b0, in_B};
    assign is_shift  = (control == 3'b101) || (control == 3'b110) || (control == 3'b111);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign zero      = zero_q;
    assign equal     = equal_q;
    assign carry     = carry_q;

    // Single-cycle result for the incoming operands (shift by zero passes A through in the iterative build)
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (control)
            3'b000: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            3'b001: begin
                alu_res   = in_A - in_B;
                alu_carry = (in_A >= in_B);
            end
            3'b010: alu_res = in_A & in_B;
            3'b011: alu_res = in_A | in_B;
            3'b100: alu_res = in_A ^ in_B;
`ifdef SEQ_ALU_FAST_SHIFT_EN
            3'b101: alu_res = in_A << shamt;
            3'b110: alu_res = in_A >> shamt;
            default: alu_res = $unsigned($signed(in_A) >>> shamt);
`else
            default: alu_res = in_A;
`endif
        endcase
    end

    // One-bit step of the working register; sra keeps the MSB so the original sign is replicated
    always_comb begin
        case (op_q)
            3'b101:  work_step = {work_q[WIDTH-2:0], 1'b0};
            3'b110:  work_step = {1'b0, work_q[WIDTH-1:1]};
            default: work_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        endcase
    end

    // Next-state and result/flag updates; outputs only change when entering DONE
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        eq_pend_d = eq_pend_q;
        out_d     = out_q;
        zero_d    = zero_q;
        equal_d   = equal_q;
        carry_d   = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef SEQ_ALU_FAST_SHIFT_EN
                    if (1'b0) begin
`else
                    if (is_shift && (shamt != '0)) begin
`endif
                        state_d   = SHIFT;
                        work_d    = in_A;
                        cnt_d     = shamt;
                        op_d      = control;
                        eq_pend_d = (in_A == in_B);
                    end else begin
                        state_d = DONE;
                        out_d   = alu_res;
                        zero_d  = (alu_res == '0);
                        equal_d = (in_A == in_B);
                        carry_d = alu_carry;
                    end
                end
            end
            SHIFT: begin
                work_d = work_step;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                    out_d   = work_step;
                    zero_d  = (work_step == '0);
                    equal_d = eq_pend_q;
                    carry_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            op_q      <= 3'b000;
            eq_pend_q <= 1'b0;
            out_q     <= '0;
            zero_q    <= 1'b0;
            equal_q   <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            eq_pend_q <= eq_pend_d;
            out_q     <= out_d;
            zero_q    <= zero_d;
            equal_q   <= equal_d;
            carry_q   <= carry_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=64) against a behavioural model.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_A = '0;
    logic [63:0] in_B = '0;
    logic [2:0]  control = 3'b000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out;
    logic        zero, equal, carry;

    int errors = 0;
    int checks = 0;

    seq_alu #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .control(control), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .zero(zero), .equal(equal), .carry(carry)
    );

    always #5 clk = ~clk;

    // Behavioural reference: result, carry and latency from the opcode rules
    function automatic void ref_model(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                                      output logic [63:0] res, output logic c, output int lat);
        logic [64:0] wide;
        int n;
        n   = int'(b[5:0]);
        c   = 1'b0;
        lat = 1;
        case (op)
            3'd0: begin wide = {1'b0, a} + {1'b0, b}; res = wide[63:0]; c = wide[64]; end
            3'd1: begin res = a - b; c = (a >= b); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = a << n;
            3'd6: res = a >> n;
            default: res = $unsigned($signed(a) >>> n);
        endcase
`ifndef SEQ_ALU_FAST_SHIFT_EN
        if (op >= 3'd5 && n > 0) lat = n + 1;
`endif
    endfunction

    // Issue one request from IDLE and wait (bounded) for out_valid; scrambles inputs after acceptance
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                          output logic rdy, output int lat);
        in_A = a; in_B = b; control = op; in_valid = 1'b1;
        rdy = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_A = {$urandom(), $urandom()};
        in_B = {$urandom(), $urandom()};
        control = 3'($urandom_range(0, 7));
        lat = 1;
        while (out_valid !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out !== 64'd0 || zero !== 1'b0 || equal !== 1'b0 || carry !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got out=%h z=%b e=%b c=%b v=%b, expected all 0", out, zero, equal, carry, out_valid);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic rdy;
        int lat;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd0, rdy, lat);
        checks++;
        if (lat !== 1 || out !== 64'd0 || zero !== 1'b1 || carry !== 1'b1 || equal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_wrap: got lat=%0d out=%h z=%b c=%b e=%b, expected lat=1 out=0 z=1 c=1 e=0", lat, out, zero, carry, equal);
        end
        consume();
        run_op(64'd5, 64'd5, 3'd1, rdy, lat);
        checks++;
        if (out !== 64'd0 || zero !== 1'b1 || equal !== 1'b1 || carry !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sub_equal: got out=%h z=%b e=%b c=%b, expected out=0 z=1 e=1 c=1", out, zero, equal, carry);
        end
        consume();
        run_op(64'd3, 64'd5, 3'd1, rdy, lat);
        checks++;
        if (out !== 64'hFFFF_FFFF_FFFF_FFFE || carry !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sub_borrow: got out=%h c=%b z=%b, expected out=fffffffffffffffe c=0 z=0", out, carry, zero);
        end
        consume();
        run_op(64'h8000_0000_0000_0000, 64'h43, 3'd7, rdy, lat);
        checks++;
`ifdef SEQ_ALU_FAST_SHIFT_EN
        if (lat !== 1 || out !== 64'hF000_0000_0000_0000) begin
            errors++;
            $display("[TB] FAIL sra_latency: got lat=%0d out=%h, expected lat=1 out=f000000000000000", lat, out);
        end
`else
        if (lat !== 4 || out !== 64'hF000_0000_0000_0000) begin
            errors++;
            $display("[TB] FAIL sra_latency: got lat=%0d out=%h, expected lat=4 out=f000000000000000", lat, out);
        end
`endif
        consume();
        run_op(64'h1234, 64'hFFC0, 3'd6, rdy, lat);
        checks++;
        if (lat !== 1 || out !== 64'h1234 || carry !== 1'b0) begin
            errors++;
            $display("[TB] FAIL shift_zero_amount: got lat=%0d out=%h c=%b, expected lat=1 out=1234 c=0", lat, out, carry);
        end
        consume();
    endtask

    task automatic test_hold();
        logic rdy;
        int lat;
        logic [63:0] exp_out;
        logic exp_c, exp_z, exp_e;
        int exp_lat;
        logic [63:0] a, b;
        int bad;
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
        ref_model(a, b, 3'd0, exp_out, exp_c, exp_lat);
        exp_z = (exp_out == 64'd0);
        exp_e = (a == b);
        run_op(a, b, 3'd0, rdy, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            in_A = {$urandom(), $urandom()};
            in_B = {$urandom(), $urandom()};
            control = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
            if (out !== exp_out || carry !== exp_c || zero !== exp_z || equal !== exp_e
                || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL hold_stable: got %0d unstable cycles, expected 0 (out=%h exp=%h)", bad, out, exp_out);
        end
        in_valid = 1'b0;
        consume();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_release: got rdy=%b v=%b, expected rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_out;
        logic exp_c;
        int exp_lat;
        logic rdy;
        int lat;
        run_op(64'd10, 64'd20, 3'd3, rdy, lat);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_A = 64'd7; in_B = 64'd9; control = 3'd4;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_ready_in_done: got %b expected 0", in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 64'd30) begin
            errors++;
            $display("[TB] FAIL b2b_not_accepted: got v=%b rdy=%b out=%h, expected v=0 rdy=1 out=1e", out_valid, in_ready, out);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        ref_model(64'd7, 64'd9, 3'd4, exp_out, exp_c, exp_lat);
        checks++;
        if (out_valid !== 1'b1 || out !== exp_out) begin
            errors++;
            $display("[TB] FAIL b2b_second: got v=%b out=%h, expected v=1 out=%h", out_valid, out, exp_out);
        end
        consume();
    endtask

    task automatic test_random();
        logic [63:0] a, b, exp_out;
        logic [2:0] op;
        logic exp_c, rdy;
        int exp_lat, lat;
        for (int i = 0; i < 40; i++) begin
            a = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = 64'($urandom_range(0, 63));
                default: b = {$urandom(), $urandom()};
            endcase
            if ($urandom_range(0, 5) == 0) a = 64'd0;
            op = 3'($urandom_range(0, 7));
            ref_model(a, b, op, exp_out, exp_c, exp_lat);
            run_op(a, b, op, rdy, lat);
            checks++;
            if (rdy !== 1'b1 || lat != exp_lat) begin
                errors++;
                $display("[TB] FAIL rand_timing[%0d]: got rdy=%b lat=%0d, expected rdy=1 lat=%0d (op=%0d)", i, rdy, lat, exp_lat, op);
            end
            checks++;
            if (out !== exp_out || carry !== exp_c || zero !== (exp_out == 64'd0) || equal !== (a == b)) begin
                errors++;
                $display("[TB] FAIL rand_result[%0d]: got out=%h c=%b z=%b e=%b, expected out=%h c=%b z=%b e=%b (op=%0d)",
                         i, out, carry, zero, equal, exp_out, exp_c, (exp_out == 64'd0), (a == b), op);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            consume();
        end
    endtask

    task automatic test_reset_abort();
        logic rdy;
        int lat;
        int seen;
        run_op(64'hABCD, 64'h1111, 3'd3, rdy, lat);
        consume();
        in_A = 64'd1; in_B = 64'd63; control = 3'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
`ifdef SEQ_ALU_FAST_SHIFT_EN
        @(posedge clk); #1;
`else
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL abort_early_valid: got %0d valid cycles expected 0", seen);
        end
`endif
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out !== 64'd0 || zero !== 1'b0 || equal !== 1'b0 || carry !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got out=%h z=%b e=%b c=%b v=%b, expected all 0", out, zero, equal, carry, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 || in_ready !== 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL abort_no_result: got %0d bad cycles expected 0", seen);
        end
        run_op(64'd2, 64'd3, 3'd0, rdy, lat);
        checks++;
        if (out !== 64'd5 || lat != 1) begin
            errors++;
            $display("[TB] FAIL abort_then_add: got out=%h lat=%0d expected out=5 lat=1", out, lat);
        end
        consume();
    endtask

    initial begin
        $display("[TB] seq_alu bench start");
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
